// File: rtl/adbg_core_halt_ctrl.sv
// ---------------------------------------------------------------------------
// adbg_core_halt_ctrl
//   CPU-clock-domain responder between the debug unit and the cores of one
//   cluster. Each core gets its own halt/resume handshake FSM, driven by the
//   debug unit's per-core stall request. Core breakpoint rising edges are
//   reported as single-cycle bp_o pulses. When cross-triggering is built in,
//   a breakpoint on one enabled core is also reported on every other enabled
//   core.
//
// Ports
//   cpu_clk_i        CPU clock
//   cpu_rstn_i       asynchronous active-low reset
//   stall_i          per-core stall request from the debug unit (level)
//   core_halted_i    per-core "halted" acknowledge from the core (level)
//   core_bkpt_i      per-core breakpoint level; a rising edge is one event
//   xtrig_en_i       per-core cross-trigger participation
//   err_clr_i        clears every timeout_o bit (pulse)
//   bp_o             per-core breakpoint event pulse to the debug unit
//   core_halt_req_o  per-core halt request to the core (level)
//   core_resume_o    per-core resume request to the core (level)
//   halted_o         per-core "in HALTED state"
//   timeout_o        per-core sticky halt-acknowledge timeout
// ---------------------------------------------------------------------------
module adbg_core_halt_ctrl #(
  parameter int unsigned NB_CORES     = 4,
  parameter int unsigned HALT_TIMEOUT = 255,
  parameter bit          CROSS_TRIG   = 1'b1
) (
  input  logic                cpu_clk_i,
  input  logic                cpu_rstn_i,
  input  logic [NB_CORES-1:0] stall_i,
  input  logic [NB_CORES-1:0] core_halted_i,
  input  logic [NB_CORES-1:0] core_bkpt_i,
  input  logic [NB_CORES-1:0] xtrig_en_i,
  input  logic                err_clr_i,
  output logic [NB_CORES-1:0] bp_o,
  output logic [NB_CORES-1:0] core_halt_req_o,
  output logic [NB_CORES-1:0] core_resume_o,
  output logic [NB_CORES-1:0] halted_o,
  output logic [NB_CORES-1:0] timeout_o
);

  localparam int unsigned CNT_W = (HALT_TIMEOUT < 2) ? 1 : $clog2(HALT_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(HALT_TIMEOUT);
  // Value the counter holds on the cycle whose "stay" makes it reach CNT_MAX.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALT_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_HALT_REQ = 2'd1,
    ST_HALTED   = 2'd2,
    ST_RESUME   = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Breakpoint edge detection and cross-trigger fan-out
  // ---------------------------------------------------------------------------
  logic [NB_CORES-1:0] bkpt_q;
  logic [NB_CORES-1:0] bkpt_ev;
  logic [NB_CORES-1:0] xtrig_src;
  logic [NB_CORES-1:0] xtrig_hit;
  logic [NB_CORES-1:0] bp_q;

  assign bkpt_ev   = core_bkpt_i & ~bkpt_q;
  assign xtrig_src = bkpt_ev & xtrig_en_i;

  // A core is cross-triggered only by another enabled core's event, so a core
  // whose own event also qualifies as a source still yields a single pulse.
  always_comb begin
    xtrig_hit = '0;
    for (int unsigned i = 0; i < NB_CORES; i++) begin
      xtrig_hit[i] = CROSS_TRIG && xtrig_en_i[i] &&
                     ((xtrig_src & ~(NB_CORES'(1) << i)) != '0);
    end
  end

  always_ff @(posedge cpu_clk_i or negedge cpu_rstn_i) begin
    if (!cpu_rstn_i) begin
      bkpt_q <= '0;
      bp_q   <= '0;
    end else begin
      bkpt_q <= core_bkpt_i;
      bp_q   <= bkpt_ev | xtrig_hit;
    end
  end

  assign bp_o = bp_q;

  // ---------------------------------------------------------------------------
  // Per-core halt/resume handshake
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NB_CORES; gi++) begin : g_core
    state_t           st_q;
    logic [CNT_W-1:0] cnt_q;
    logic             halt_req_q;
    logic             resume_q;
    logic             halted_q;
    logic             timeout_q;

    // Outputs are updated on the same edge as the state they describe, so a
    // request appears in the cycle right after the triggering input.
    always_ff @(posedge cpu_clk_i or negedge cpu_rstn_i) begin
      if (!cpu_rstn_i) begin
        st_q       <= ST_RUN;
        cnt_q      <= '0;
        halt_req_q <= 1'b0;
        resume_q   <= 1'b0;
        halted_q   <= 1'b0;
        timeout_q  <= 1'b0;
      end else begin
        // Clear first; a timeout set later in this block takes precedence.
        if (err_clr_i) begin
          timeout_q <= 1'b0;
        end

        case (st_q)
          ST_RUN: begin
            if (stall_i[gi]) begin
              st_q       <= ST_HALT_REQ;
              halt_req_q <= 1'b1;
              cnt_q      <= '0;
            end
          end

          ST_HALT_REQ: begin
            if (core_halted_i[gi]) begin
              st_q     <= ST_HALTED;
              halted_q <= 1'b1;
              cnt_q    <= '0;
            end else if (!stall_i[gi]) begin
              st_q       <= ST_RUN;
              halt_req_q <= 1'b0;
              cnt_q      <= '0;
            end else begin
              if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
              // Counter is (or becomes) saturated: flag the missing ack and
              // keep waiting for it.
              if (cnt_q >= CNT_LAST) begin
                timeout_q <= 1'b1;
              end
            end
          end

          ST_HALTED: begin
            if (!stall_i[gi]) begin
              st_q       <= ST_RESUME;
              halt_req_q <= 1'b0;
              halted_q   <= 1'b0;
              resume_q   <= 1'b1;
            end
          end

          ST_RESUME: begin
            // stall_i is deliberately ignored until the core has left halt.
            if (!core_halted_i[gi]) begin
              st_q     <= ST_RUN;
              resume_q <= 1'b0;
            end
          end

          default: begin
            st_q       <= ST_RUN;
            cnt_q      <= '0;
            halt_req_q <= 1'b0;
            resume_q   <= 1'b0;
            halted_q   <= 1'b0;
          end
        endcase
      end
    end

    assign core_halt_req_o[gi] = halt_req_q;
    assign core_resume_o[gi]   = resume_q;
    assign halted_o[gi]        = halted_q;
    assign timeout_o[gi]       = timeout_q;
  end

endmodule

// File: tb/tb_adbg_core_halt_ctrl.sv
// ---------------------------------------------------------------------------
// tb_adbg_core_halt_ctrl
//   Directed scenarios followed by a randomized run of adbg_core_halt_ctrl,
//   every cycle compared with a behavioural model of the halt handshake,
//   timeout and breakpoint reporting rules.
// ---------------------------------------------------------------------------
module tb_adbg_core_halt_ctrl;

  localparam int NB = 4;
  localparam int TO = 8;

  logic          clk;
  logic          rstn;
  logic [NB-1:0] stall;
  logic [NB-1:0] chalt;
  logic [NB-1:0] bk;
  logic [NB-1:0] xen;
  logic          clr;
  logic [NB-1:0] bp;
  logic [NB-1:0] hreq;
  logic [NB-1:0] res;
  logic [NB-1:0] hlt;
  logic [NB-1:0] tmo;

  int checks = 0;
  int errors = 0;

  adbg_core_halt_ctrl #(
    .NB_CORES    (NB),
    .HALT_TIMEOUT(TO),
    .CROSS_TRIG  (1'b1)
  ) dut (
    .cpu_clk_i      (clk),
    .cpu_rstn_i     (rstn),
    .stall_i        (stall),
    .core_halted_i  (chalt),
    .core_bkpt_i    (bk),
    .xtrig_en_i     (xen),
    .err_clr_i      (clr),
    .bp_o           (bp),
    .core_halt_req_o(hreq),
    .core_resume_o  (res),
    .halted_o       (hlt),
    .timeout_o      (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: per core, what the core has been asked to do.
  bit m_req  [NB];   // halt requested (also held while halted)
  bit m_hlt  [NB];   // halt acknowledged
  bit m_res  [NB];   // resume requested
  bit m_to   [NB];
  bit m_bkq  [NB];
  bit m_bp   [NB];
  int m_wait [NB];   // cycles spent waiting for the ack beyond the first

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      m_req[i] = 0; m_hlt[i] = 0; m_res[i] = 0; m_to[i] = 0;
      m_bkq[i] = 0; m_bp[i] = 0; m_wait[i] = 0;
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    bit ev [NB];
    bit other;
    bit set_now;
    for (int i = 0; i < NB; i++) ev[i] = bk[i] && !m_bkq[i];
    for (int i = 0; i < NB; i++) begin
      other = 0;
      for (int j = 0; j < NB; j++)
        if (j != i && ev[j] && xen[j]) other = 1;
      m_bp[i]  = ev[i] || (xen[i] && other);
      m_bkq[i] = bk[i];
    end
    for (int i = 0; i < NB; i++) begin
      set_now = 0;
      if (m_res[i]) begin
        if (!chalt[i]) m_res[i] = 0;
      end else if (m_hlt[i]) begin
        if (!stall[i]) begin m_hlt[i] = 0; m_req[i] = 0; m_res[i] = 1; end
      end else if (m_req[i]) begin
        if (chalt[i]) begin m_hlt[i] = 1; m_wait[i] = 0; end
        else if (!stall[i]) begin m_req[i] = 0; m_wait[i] = 0; end
        else begin
          m_wait[i]++;
          if (m_wait[i] >= TO) set_now = 1;
        end
      end else if (stall[i]) begin
        m_req[i] = 1; m_wait[i] = 0;
      end
      m_to[i] = set_now ? 1'b1 : (clr ? 1'b0 : m_to[i]);
    end
  endtask

  task automatic compare_all();
    logic [NB-1:0] e_bp, e_req, e_res, e_hlt, e_to;
    for (int i = 0; i < NB; i++) begin
      e_bp[i] = m_bp[i]; e_req[i] = m_req[i]; e_res[i] = m_res[i];
      e_hlt[i] = m_hlt[i]; e_to[i] = m_to[i];
    end
    chk("bp_o",        32'(bp),   32'(e_bp));
    chk("halt_req_o",  32'(hreq), 32'(e_req));
    chk("resume_o",    32'(res),  32'(e_res));
    chk("halted_o",    32'(hlt),  32'(e_hlt));
    chk("timeout_o",   32'(tmo),  32'(e_to));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Reset in the middle of a cycle; outputs must fall without a clock edge.
  task automatic mid_reset();
    #3;
    rstn = 1'b0;
    #1;
    chk("rst_async_outs", 32'({bp, hreq, res, hlt, tmo}), 32'd0);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; stall = '0; chalt = '0; bk = '0; xen = '0; clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", 32'({bp, hreq, res, hlt, tmo}), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // 1: halt core0, ack after 5 cycles, then resume
    stall = 4'b0001; tick();
    chk("t1_req_n1", 32'(hreq), 32'h1);
    ticks(4);
    chalt = 4'b0001; tick();
    chk("t1_halted", 32'(hlt), 32'h1);
    stall = 4'b0000; tick();
    chk("t1_resume", 32'(res), 32'h1);
    ticks(3);
    chalt = 4'b0000; tick();
    chk("t1_run", 32'({res, hreq}), 32'h0);

    // 2: stall pulse of 3 cycles without ack cancels cleanly
    stall = 4'b0010; ticks(3);
    stall = 4'b0000; tick();
    chk("t2_cancel", 32'({hreq, tmo}), 32'h0);
    tick();

    // 3: timeout after HALT_TIMEOUT cycles, survives the ack, cleared by err_clr
    stall = 4'b0100; ticks(TO);
    chk("t3_no_to_yet", 32'(tmo), 32'h0);
    tick();
    chk("t3_timeout", 32'(tmo), 32'h4);
    ticks(2);
    chalt = 4'b0100; tick();
    chk("t3_halted_to", 32'({hlt, tmo}), 32'h44);
    clr = 1'b1; tick();
    clr = 1'b0;
    chk("t3_cleared", 32'(tmo), 32'h0);
    stall = 4'b0000; tick();
    chalt = 4'b0000; ticks(2);

    // 4: cross-trigger from core0, held level gives one pulse
    xen = 4'b1011; bk = 4'b0001; tick();
    chk("t4_xtrig", 32'(bp), 32'hb);
    ticks(9);
    bk = 4'b0000; tick();

    // 5: simultaneous breakpoints, no cross-trigger
    xen = 4'b0000; bk = 4'b0011; tick();
    chk("t5_simul", 32'(bp), 32'h3);
    ticks(3);
    bk = 4'b0000; tick();

    // 6: reset while core3 has a resume pending, then a fresh halt
    stall = 4'b1000; tick();
    chalt = 4'b1000; tick();
    stall = 4'b0000; tick();
    chk("t6_pending", 32'(res), 32'h8);
    mid_reset();
    chalt = 4'b0000;
    stall = 4'b1000; tick();
    chk("t6_fresh_req", 32'(hreq), 32'h8);
    stall = 4'b0000; ticks(2);

    // Randomized run: slowly varying levels, responsive-ish cores
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NB; i++) begin
        if ($urandom_range(0, 7) == 0) stall[i] = ~stall[i];
        if (chalt[i] != (hreq[i] | hlt[i])) begin
          if ($urandom_range(0, 3) == 0) chalt[i] = ~chalt[i];
        end else if ($urandom_range(0, 31) == 0) begin
          chalt[i] = ~chalt[i];
        end
        if ($urandom_range(0, 5) == 0) bk[i] = ~bk[i];
      end
      if ($urandom_range(0, 63) == 0) xen = NB'($urandom);
      clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 499) == 0) mid_reset();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
